writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Write-back stage that produces the register-file write port consumed by the decode stage: RegWrite, WriteReg and WriteData.
- Merges two result sources:
  - the in-order pipeline (MEM/WB results, ALU or load data);
  - the out-of-order, multi-cycle Booth multiplier.
- Multiplier completions are held in a small FIFO and drained into free write slots.
- Asserts a pipeline stall when the FIFO has been starved for too long.

Parameters:
- DEPTH, 2, multiplier-result FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may go undrained before stall_pipe asserts.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- pipe_valid  input  1  MEM/WB instruction valid this cycle.
- pipe_reg_write  input  1  instruction writes a register.
- pipe_mem_to_reg  input  1  1 = select pipe_mem_data, 0 = pipe_alu_result.
- pipe_dest  input  5  destination register.
- pipe_alu_result  input  32  ALU result.
- pipe_mem_data  input  32  load data.
- mul_valid  input  1  multiplier result offered.
- mul_dest  input  5  multiplier destination register.
- mul_result  input  32  multiplier result.
- mul_ready  output  1  FIFO can accept a result (combinational, = not full).
- RegWrite  output  1  register-file write enable to decode stage.
- WriteReg  output  5  register-file write address.
- WriteData  output  32  register-file write data.
- stall_pipe  output  1  request that the pipeline insert a bubble next cycle.

Behaviour:
- Reset (async, immediate):
  - RegWrite=0, WriteReg=0, WriteData=0, stall_pipe=0.
  - FIFO emptied, pointers and count=0, starvation counter=0.
  - mul_ready=1 once rst deasserts.
- Pipe write and write slot:
  - pipe_w = pipe_valid & pipe_reg_write & (pipe_dest != 0).
  - A cycle with pipe_valid=0 or pipe_reg_write=0 is a free write slot.
- Outputs are registered, 1-cycle latency from inputs to RegWrite/WriteReg/WriteData.
- Priority each cycle:
  1. pipe_w: output the pipe result (mux on pipe_mem_to_reg).
  2. Else FIFO non-empty: output the head entry and pop it.
  3. Else RegWrite=0; WriteReg/WriteData hold their previous values.
- Register 0 never written:
  - pipe writes to dest 0 give RegWrite=0, and the slot counts as free.
  - mul results with mul_dest=0 are accepted (handshake completes) but not enqueued.
- Multiplier handshake:
  - Transfer when mul_valid & mul_ready.
  - The result is pushed at that edge and is not drainable in the same cycle; earliest output is 2 cycles after acceptance.
  - mul_valid with mul_ready=0: the multiplier holds its data, nothing is lost.
- Simultaneous push and pop when full: not allowed, mul_ready is already 0. Push and pop in the same cycle when non-full: count is unchanged.
- WAW ordering:
  - Pipeline instructions are younger than any outstanding multiply.
  - On a pipe_w cycle, every valid FIFO entry with dest == pipe_dest is invalidated.
  - A mul result accepted that same cycle with mul_dest == pipe_dest is discarded.
  - An invalidated entry reaching the head is popped without writing and consumes no slot; the next valid entry may drain in the same cycle if the slot is free.
- Starvation counter:
  - Increments each cycle the FIFO holds a valid entry and pipe_w=1.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_pipe:
  - Registered; high while counter == STARVE_LIMIT.
  - The upstream pipeline then presents pipe_valid=0, creating a free slot; the drain clears the counter, so stall_pipe drops the following cycle.
- Reset mid-operation: buffered multiplier results are discarded with no partial write; RegWrite falls immediately.

Test Plan:
- Reset, then pipe_valid=1, pipe_reg_write=1, pipe_dest=7, pipe_alu_result=15, pipe_mem_to_reg=0 -> next edge RegWrite=1, WriteReg=7, WriteData=15. Repeat with pipe_mem_to_reg=1, pipe_mem_data=0xDEADBEEF -> WriteData=0xDEADBEEF.
- Pipeline idle, mul_valid=1, mul_dest=9, mul_result=0x00000190 for one cycle -> mul_ready=1. Two cycles later RegWrite=1, WriteReg=9, WriteData=0x190, and the FIFO returns empty.
- Pipe writes every cycle to reg 3 while mul results to regs 10 then 11 arrive -> after the 2nd accept mul_ready=0, and a 3rd mul_valid is held. After 4 starved cycles stall_pipe=1. With the pipeline idle, reg 10 then 11 are written in order and stall_pipe falls.
- Mul result for reg 5 buffered behind a pipe write, then pipe write to reg 5 value 0x22 -> reg 5 written once with 0x22, and the stale multiplier value is never written.
- pipe_dest=0 with value 0x55 plus a buffered mul result for reg 4 -> RegWrite never asserts with WriteReg=0, and reg 4 drains in that cycle.
- FIFO holding 2 entries, rst pulsed mid-cycle -> RegWrite=0 and stall_pipe=0 immediately, mul_ready=1 after release, and no buffered result is ever written.

Source files
------------

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges in-order MEM/WB results with buffered multiplier completions onto the register-file write port.
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic        pipe_reg_write,
    input  logic        pipe_mem_to_reg,
    input  logic [4:0]  pipe_dest,
    input  logic [31:0] pipe_alu_result,
    input  logic [31:0] pipe_mem_data,
    input  logic        mul_valid,
    input  logic [4:0]  mul_dest,
    input  logic [31:0] mul_result,
    output logic        mul_ready,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic        stall_pipe
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [4:0]       f_dest [DEPTH];
    logic [31:0]      f_data [DEPTH];
    logic [DEPTH-1:0] f_vld;
    logic [AW-1:0]    rptr, wptr, h1, didx;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve, starve_next;
    logic             pipe_w, n0, n1, v0, v1, skip, drain, enq;
    logic [1:0]       pops;
    assign pipe_w    = pipe_valid & pipe_reg_write & (pipe_dest != 5'd0);
    assign mul_ready = count != CW'(DEPTH);
    assign h1        = rptr + AW'(1);
    // An invalidated head is skipped for free, letting the entry behind it use this slot.
    always_comb begin
        n0    = count != '0;
        n1    = count > CW'(1);
        v0    = n0 & f_vld[rptr];
        v1    = n1 & f_vld[h1];
        skip  = n0 & ~v0;
        drain = ~pipe_w & (v0 | (skip & v1));
        didx  = v0 ? rptr : h1;
        pops  = skip ? ((~pipe_w & v1) ? 2'd2 : 2'd1) : {1'b0, drain};
        enq   = mul_valid & mul_ready & (mul_dest != 5'd0) & ~(pipe_w & (mul_dest == pipe_dest));
        starve_next = (pops != 2'd0 || !n0) ? '0 :
                      (pipe_w && starve != SW'(STARVE_LIMIT)) ? starve + SW'(1) : starve;
    end
    always_ff @(posedge clk) begin
        if (enq) begin
            f_dest[wptr] <= mul_dest;
            f_data[wptr] <= mul_result;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            WriteReg   <= '0;
            WriteData  <= '0;
            stall_pipe <= 1'b0;
            f_vld      <= '0;
            rptr       <= '0;
            wptr       <= '0;
            count      <= '0;
            starve     <= '0;
        end else begin
            RegWrite <= pipe_w | drain;
            if (pipe_w) begin
                WriteReg  <= pipe_dest;
                WriteData <= pipe_mem_to_reg ? pipe_mem_data : pipe_alu_result;
            end else if (drain) begin
                WriteReg  <= f_dest[didx];
                WriteData <= f_data[didx];
            end
            // A younger pipeline write to the same register makes buffered results stale.
            for (int i = 0; i < DEPTH; i++)
                if (pipe_w && f_dest[i] == pipe_dest) f_vld[i] <= 1'b0;
            if (pops != 2'd0) f_vld[rptr] <= 1'b0;
            if (pops == 2'd2) f_vld[h1] <= 1'b0;
            if (enq) f_vld[wptr] <= 1'b1;
            wptr       <= wptr + AW'(enq);
            rptr       <= rptr + AW'(pops);
            count      <= count + CW'(enq) - CW'(pops);
            starve     <= starve_next;
            stall_pipe <= starve_next == SW'(STARVE_LIMIT);
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: table-driven cycle vectors plus hand-written reset sequences for writeback_arbiter.
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, pipe_reg_write, pipe_mem_to_reg;
    logic [4:0]  pipe_dest;
    logic [31:0] pipe_alu_result, pipe_mem_data;
    logic        mul_valid;
    logic [4:0]  mul_dest;
    logic [31:0] mul_result;
    logic        mul_ready, RegWrite, stall_pipe;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_reg_write(pipe_reg_write), .pipe_mem_to_reg(pipe_mem_to_reg),
        .pipe_dest(pipe_dest), .pipe_alu_result(pipe_alu_result), .pipe_mem_data(pipe_mem_data),
        .mul_valid(mul_valid), .mul_dest(mul_dest), .mul_result(mul_result), .mul_ready(mul_ready),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData), .stall_pipe(stall_pipe)
    );

    typedef struct {
        logic        pv, prw, m2r;
        logic [4:0]  pd;
        logic [31:0] alu, mem;
        logic        mv;
        logic [4:0]  md;
        logic [31:0] mr;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        rdy, st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic pv, prw, m2r, input logic [4:0] pd, input logic [31:0] alu, mem,
                                input logic mv, input logic [4:0] md, input logic [31:0] mr,
                                input logic rw, input logic [4:0] wr, input logic [31:0] wd, input logic rdy, st);
        vec_t r;
        r.pv = pv; r.prw = prw; r.m2r = m2r; r.pd = pd; r.alu = alu; r.mem = mem;
        r.mv = mv; r.md = md; r.mr = mr; r.rw = rw; r.wr = wr; r.wd = wd; r.rdy = rdy; r.st = st;
        return r;
    endfunction

    task automatic drive(input logic pv, prw, m2r, input logic [4:0] pd, input logic [31:0] alu, mem,
                         input logic mv, input logic [4:0] md, input logic [31:0] mr);
        pipe_valid = pv; pipe_reg_write = prw; pipe_mem_to_reg = m2r; pipe_dest = pd;
        pipe_alu_result = alu; pipe_mem_data = mem; mul_valid = mv; mul_dest = md; mul_result = mr;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    initial begin
        // cycle-by-cycle table starting from reset; expected outputs are those seen after that cycle's edge
        vecs.push_back(mk(1,1,0, 7, 32'd15, 0,            0, 0, 0,       1, 7, 32'd15,       1, 0));
        vecs.push_back(mk(1,1,1, 7, 0, 32'hDEADBEEF,      0, 0, 0,       1, 7, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 1, 9, 32'h190, 0, 7, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 0, 0, 0,       1, 9, 32'h190,      1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 0, 0, 0,       0, 9, 32'h190,      1, 0));
        vecs.push_back(mk(1,1,0, 3, 32'h30, 0,            1, 10, 32'hA0, 1, 3, 32'h30,       1, 0));
        vecs.push_back(mk(1,1,0, 3, 32'h31, 0,            1, 11, 32'hB0, 1, 3, 32'h31,       0, 0));
        vecs.push_back(mk(1,1,0, 3, 32'h32, 0,            1, 12, 32'hC0, 1, 3, 32'h32,       0, 0));
        vecs.push_back(mk(1,1,0, 3, 32'h33, 0,            1, 12, 32'hC0, 1, 3, 32'h33,       0, 0));
        vecs.push_back(mk(1,1,0, 3, 32'h34, 0,            1, 12, 32'hC0, 1, 3, 32'h34,       0, 1));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 1, 12, 32'hC0, 1, 10, 32'hA0,      1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 1, 12, 32'hC0, 1, 11, 32'hB0,      1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 0, 0, 0,       1, 12, 32'hC0,      1, 0));
        vecs.push_back(mk(1,1,0, 3, 32'h40, 0,            1, 5, 32'h55AA, 1, 3, 32'h40,      1, 0));
        vecs.push_back(mk(1,1,0, 5, 32'h22, 0,            0, 0, 0,       1, 5, 32'h22,       1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 0, 0, 0,       0, 5, 32'h22,       1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 0, 0, 0,       0, 5, 32'h22,       1, 0));
        vecs.push_back(mk(1,1,0, 3, 32'h50, 0,            1, 4, 32'h44,  1, 3, 32'h50,       1, 0));
        vecs.push_back(mk(1,1,0, 0, 32'h55, 0,            0, 0, 0,       1, 4, 32'h44,       1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 0, 0, 0,       0, 4, 32'h44,       1, 0));
        vecs.push_back(mk(1,1,0, 6, 32'h60, 0,            1, 6, 32'h66,  1, 6, 32'h60,       1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 0, 0, 0,       0, 6, 32'h60,       1, 0));
        vecs.push_back(mk(1,1,0, 3, 32'h70, 0,            1, 8, 32'h80,  1, 3, 32'h70,       1, 0));
        vecs.push_back(mk(1,1,0, 8, 32'h88, 0,            1, 9, 32'h99,  1, 8, 32'h88,       0, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 0, 0, 0,       1, 9, 32'h99,       1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 1, 0, 32'hDD,  0, 9, 32'h99,       1, 0));
        vecs.push_back(mk(0,0,0, 0, 0, 0,                 0, 0, 0,       0, 9, 32'h99,       1, 0));
        vecs.push_back(mk(1,0,0, 7, 32'h1, 0,             1, 13, 32'hD0, 0, 9, 32'h99,       1, 0));
        vecs.push_back(mk(1,0,0, 7, 32'h1, 0,             0, 0, 0,       1, 13, 32'hD0,      1, 0));

        rst = 1'b1;
        drive(0,0,0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_regwrite", 32'(RegWrite), 0);
        chk("reset_writereg", 32'(WriteReg), 0);
        chk("reset_writedata", WriteData, 0);
        chk("reset_stall", 32'(stall_pipe), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ready", 32'(mul_ready), 1);
        @(negedge clk);

        foreach (vecs[k]) begin
            drive(vecs[k].pv, vecs[k].prw, vecs[k].m2r, vecs[k].pd, vecs[k].alu, vecs[k].mem,
                  vecs[k].mv, vecs[k].md, vecs[k].mr);
            step();
            n_tests++;
            if (RegWrite !== vecs[k].rw || WriteReg !== vecs[k].wr || WriteData !== vecs[k].wd ||
                mul_ready !== vecs[k].rdy || stall_pipe !== vecs[k].st) begin
                n_fail++;
                $display("FAIL vec%0d: got rw=%b wr=%0d wd=0x%08h rdy=%b st=%b expected rw=%b wr=%0d wd=0x%08h rdy=%b st=%b",
                         k, RegWrite, WriteReg, WriteData, mul_ready, stall_pipe,
                         vecs[k].rw, vecs[k].wr, vecs[k].wd, vecs[k].rdy, vecs[k].st);
            end
        end

        // fill the FIFO behind continuous pipe writes, then reset asynchronously mid-cycle
        drive(1,1,0, 3, 32'h90, 0, 1, 20, 32'h2020);
        step();
        drive(1,1,0, 3, 32'h91, 0, 1, 21, 32'h2121);
        step();
        chk("full_ready", 32'(mul_ready), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1,1,0, 3, 32'h92 + 32'(i), 0, 0, 0, 0);
            step();
        end
        chk("prereset_stall", 32'(stall_pipe), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_regwrite", 32'(RegWrite), 0);
        chk("midreset_stall", 32'(stall_pipe), 0);
        drive(0,0,0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postreset_ready", 32'(mul_ready), 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("postreset_no_write", 32'(RegWrite), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
